// File: rtl/generic_slave_mem.sv
// generic_slave_mem: flop-array memory slave on the generic scanned bus
// Ports: clk, rst_n (async active-low); cs/cmd/burst/size/addr/wdata command and
// write data from the master; rdata/status/busy registered responses to the master.
module generic_slave_mem #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs,
    input  logic             cmd,
    input  logic [7:0]       burst,
    input  logic [7:0]       size,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             status,
    output logic             busy
);
    localparam int OFF = $clog2(WIDTH / 8);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [3:0] W = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_TURN} state_t;

    state_t           state;
    logic             cmd_r;
    logic [WIDTH-1:0] addr_r;
    logic [7:0]       rem;
    logic [7:0]       step;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] nxt_addr;
    logic             rd_cmd;
    logic             enter_beat;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic             unused_ok;

    // nxt_addr is the byte address of the beat being entered on the next edge,
    // so a read beat's data is fetched on that same edge.
    always_comb begin
        nxt_addr   = state == S_IDLE ? addr : state == S_BEAT ? addr_r + WIDTH'(step) : addr_r;
        rd_cmd     = state == S_IDLE ? cmd : cmd_r;
        rd_idx     = nxt_addr[OFF +: AW];
        wr_idx     = addr_r[OFF +: AW];
        enter_beat = (state == S_IDLE && cs && burst != 8'd0 && W == 4'd0) ||
                     (state == S_WAIT && cnt == 4'd1) ||
                     (state == S_BEAT && rem != 8'd1 && W == 4'd0);
        unused_ok  = ^{nxt_addr, size[7:4]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            status <= 1'b0;
            busy   <= 1'b0;
            rdata  <= '0;
            rem    <= '0;
            cnt    <= '0;
            cmd_r  <= 1'b0;
            addr_r <= '0;
            step   <= '0;
        end else begin
            status <= enter_beat;
            if (enter_beat && !rd_cmd) rdata <= mem[rd_idx];
            case (state)
                S_IDLE: if (cs) begin
                    cmd_r  <= cmd;
                    addr_r <= addr;
                    rem    <= burst;
                    step   <= 8'd1 << size[3:0];
                    if (burst != 8'd0) begin
                        busy  <= 1'b1;
                        cnt   <= W;
                        state <= W == 4'd0 ? S_BEAT : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_BEAT;
                end
                S_BEAT: begin
                    addr_r <= nxt_addr;
                    rem    <= rem - 8'd1;
                    cnt    <= W;
                    state  <= rem == 8'd1 ? S_TURN : W == 4'd0 ? S_BEAT : S_WAIT;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Memory is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (state == S_BEAT && cmd_r) mem[wr_idx] <= wdata;
    end
endmodule

// File: tb/tb_generic_slave_mem.sv
// tb_generic_slave_mem: randomized bench for generic_slave_mem with a cycle-indexed reference model
module tb_generic_slave_mem;
    localparam int N = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs [2];
    logic        cmd [2];
    logic [7:0]  burst [2];
    logic [7:0]  size [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        status [2];
    logic        busy [2];

    int cyc = 0;
    int vectors = 0;
    int errors = 0;
    int free [2];

    // Expected behaviour per DUT per cycle, filled in when a command is accepted.
    bit          exp_st [2][N];
    bit          exp_bz [2][N];
    bit          wr_ev [2][N];
    bit          rd_ev [2][N];
    int          ev_idx [2][N];
    logic [31:0] wd_val [2][N];
    bit          lit_sv [2][N];
    bit          lit_st [2][N];
    bit          lit_bv [2][N];
    bit          lit_bz [2][N];
    bit          lit_rv [2][N];
    logic [31:0] lit_rd [2][N];
    logic [31:0] mem_m [2][16];
    logic [31:0] cur_rd [2] = '{32'd0, 32'd0};
    logic [31:0] wq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generic_slave_mem #(.WIDTH(32), .DEPTH(16), .WAIT_STATES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .cs(cs[0]), .cmd(cmd[0]), .burst(burst[0]), .size(size[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .status(status[0]), .busy(busy[0])
    );

    generic_slave_mem #(.WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .cs(cs[1]), .cmd(cmd[1]), .burst(burst[1]), .size(size[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .status(status[1]), .busy(busy[1])
    );

    task automatic check(input string what, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", what, d, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) cur_rd[d] = '0;
            else if (rd_ev[d][cyc]) cur_rd[d] = mem_m[d][ev_idx[d][cyc]];
            check("status", d, 32'(status[d]), 32'(exp_st[d][cyc]));
            check("busy", d, 32'(busy[d]), 32'(exp_bz[d][cyc]));
            check("rdata", d, rdata[d], cur_rd[d]);
            if (lit_sv[d][cyc]) check("status_lit", d, 32'(status[d]), 32'(lit_st[d][cyc]));
            if (lit_bv[d][cyc]) check("busy_lit", d, 32'(busy[d]), 32'(lit_bz[d][cyc]));
            if (lit_rv[d][cyc]) check("rdata_lit", d, rdata[d], lit_rd[d][cyc]);
            if (rst_n && wr_ev[d][cyc]) mem_m[d][ev_idx[d][cyc]] = wd_val[d][cyc];
        end
    end

    task automatic lit(input int d, input int c, input int kind, input logic [31:0] v);
        if (kind == 0) begin lit_sv[d][c] = 1'b1; lit_st[d][c] = v[0]; end
        else if (kind == 1) begin lit_bv[d][c] = 1'b1; lit_bz[d][c] = v[0]; end
        else begin lit_rv[d][c] = 1'b1; lit_rd[d][c] = v; end
    endtask

    // Advance one cycle and drive that cycle's inputs; cs is junk while the DUT is busy
    // and always high in the turnaround cycle, where it must be ignored.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc > N - 400) begin
            $display("FAIL cycle_budget at cycle %0d", cyc);
            $fatal(1, "cycle budget exhausted");
        end
        for (int d = 0; d < 2; d++) begin
            wdata[d] = wr_ev[d][cyc] ? wd_val[d][cyc] : $urandom();
            cs[d]    = cyc < free[d] && (cyc == free[d] - 1 || $urandom_range(1) == 1);
            cmd[d]   = 1'($urandom_range(1));
            burst[d] = 8'($urandom());
            size[d]  = 8'($urandom());
            addr[d]  = $urandom();
        end
    endtask

    task automatic issue(input int d, input bit c, input int b, input int s, input logic [31:0] a, output int c0);
        int w = d == 0 ? 1 : 0;
        logic [31:0] x = a;
        int st = (s % 16) < 8 ? 1 << (s % 16) : 0;
        while (cyc < free[d]) tick();
        c0 = cyc;
        cs[d] = 1'b1;
        cmd[d] = c;
        burst[d] = 8'(b);
        size[d] = 8'(s);
        addr[d] = a;
        for (int n = 1; n <= b; n++) begin
            int cc = c0 + n * (1 + w);
            exp_st[d][cc] = 1'b1;
            ev_idx[d][cc] = int'((x >> 2) % 16);
            if (c) begin
                wr_ev[d][cc] = 1'b1;
                wd_val[d][cc] = wq.size() > 0 ? wq.pop_front() : $urandom();
            end else rd_ev[d][cc] = 1'b1;
            x = x + 32'(st);
        end
        for (int cc = c0 + 1; b > 0 && cc <= c0 + b * (1 + w) + 1; cc++) exp_bz[d][cc] = 1'b1;
        free[d] = b > 0 ? c0 + b * (1 + w) + 2 : c0 + 1;
        tick();
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            free[d] = 1 << 30;
            for (int c = cyc; c < N; c++) begin
                exp_st[d][c] = 1'b0;
                exp_bz[d][c] = 1'b0;
                wr_ev[d][c] = 1'b0;
                rd_ev[d][c] = 1'b0;
            end
        end
        repeat (hold) tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            free[d] = cyc;
            cs[d] = 1'b0;
        end
    endtask

    initial begin
        int c0;
        int rd;
        int rb;
        int rs;
        for (int d = 0; d < 2; d++) begin
            cs[d] = 1'b0;
            cmd[d] = 1'b0;
            burst[d] = 8'd0;
            size[d] = 8'd0;
            addr[d] = 32'd0;
            wdata[d] = 32'd0;
        end
        for (int d = 0; d < 2; d++) begin
            lit(d, 2, 0, 32'd0);
            lit(d, 2, 1, 32'd0);
            lit(d, 2, 2, 32'd0);
        end
        do_reset(3);
        lit(0, cyc + 5, 0, 32'd0);
        lit(1, cyc + 5, 1, 32'd0);
        repeat (10) tick();

        for (int i = 0; i < 16; i++) wq.push_back($urandom());
        issue(0, 1'b1, 16, 2, 32'h0, c0);
        issue(1, 1'b1, 16, 2, 32'h0, c0);

        wq.push_back(32'hDEADBEEF);
        issue(0, 1'b1, 1, 2, 32'h10, c0);
        lit(0, c0 + 1, 0, 32'd0);
        lit(0, c0 + 2, 0, 32'd1);
        lit(0, c0 + 3, 0, 32'd0);
        lit(0, c0 + 3, 1, 32'd1);
        lit(0, c0 + 4, 1, 32'd0);
        lit(0, c0 + 6, 0, 32'd1);
        lit(0, c0 + 6, 2, 32'hDEADBEEF);
        issue(0, 1'b0, 1, 2, 32'h10, c0);

        for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
        issue(1, 1'b1, 4, 2, 32'h100, c0);
        for (int i = 1; i <= 4; i++) begin
            lit(1, c0 + i, 0, 32'd1);
            lit(1, c0 + 6 + i, 2, 32'(i));
        end
        lit(1, c0 + 5, 0, 32'd0);
        lit(1, c0 + 5, 1, 32'd1);
        issue(1, 1'b0, 4, 2, 32'h100, c0);

        wq.push_back(32'hA);
        wq.push_back(32'hB);
        issue(0, 1'b1, 2, 2, 32'h3C, c0);
        lit(0, c0 + 8, 2, 32'hA);
        lit(0, c0 + 12, 2, 32'hB);
        issue(0, 1'b0, 1, 2, 32'h3C, c0);
        issue(0, 1'b0, 1, 2, 32'h0, c0);

        issue(0, 1'b1, 0, 2, 32'h3C, c0);
        lit(0, c0 + 1, 1, 32'd0);
        lit(0, c0 + 1, 0, 32'd0);
        lit(0, c0 + 2, 0, 32'd0);
        lit(0, c0 + 3, 0, 32'd1);
        lit(0, c0 + 3, 2, 32'hA);
        issue(0, 1'b0, 1, 2, 32'h3C, c0);

        while (cyc < free[0]) tick();
        issue(1, 1'b0, 4, 2, 32'h100, c0);
        lit(1, c0 + 1, 0, 32'd1);
        lit(1, c0 + 1, 2, 32'd1);
        tick();
        lit(1, cyc, 0, 32'd0);
        lit(1, cyc, 2, 32'd0);
        lit(1, cyc, 1, 32'd0);
        do_reset(2);
        lit(1, cyc, 0, 32'd0);
        lit(1, cyc, 1, 32'd0);

        wq.push_back(32'h12345678);
        issue(1, 1'b1, 1, 2, 32'h20, c0);
        while (cyc < free[1]) tick();
        do_reset(2);
        issue(1, 1'b0, 1, 2, 32'h20, c0);
        lit(1, c0 + 1, 0, 32'd1);
        lit(1, c0 + 1, 2, 32'h12345678);

        issue(1, 1'b1, 255, 2, 32'h0, c0);
        lit(1, c0 + 1, 0, 32'd1);
        lit(1, c0 + 255, 0, 32'd1);
        lit(1, c0 + 256, 0, 32'd0);
        lit(1, c0 + 256, 1, 32'd1);
        lit(1, c0 + 257, 1, 32'd0);
        while (cyc < free[1]) tick();

        repeat (60) begin
            rd = $urandom_range(1);
            rb = $urandom_range(4) == 0 ? 0 : $urandom_range(6, 1);
            rs = $urandom_range(3) == 0 ? $urandom_range(255) : $urandom_range(3);
            issue(rd, 1'($urandom_range(1)), rb, rs, $urandom(), c0);
            if ($urandom_range(9) == 0) begin
                repeat ($urandom_range(4)) tick();
                do_reset($urandom_range(3, 1));
            end
        end

        while (cyc < free[0] || cyc < free[1]) tick();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
